// File: rtl/process_run_queue.sv
// Circular FIFO of runnable PIDs; PID 0 means "no process" and is never stored.
// Optional duplicate suppression is compiled in with `define RUN_QUEUE_DEDUP_EN.
module process_run_queue #(
  parameter int pidBits   = 8,
  parameter int depthLog2 = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pushValid,
  input  logic [pidBits-1:0]   pushPid,
  output logic                 pushReady,
  output logic                 pushRejected,
  input  logic                 popRequest,
  output logic                 popValid,
  output logic [pidBits-1:0]   popPid,
  output logic [depthLog2:0]   count,
  output logic                 empty,
  output logic                 full
);

  localparam int depth = 1 << depthLog2;
  localparam logic [depthLog2:0]   countFull = {1'b1, {depthLog2{1'b0}}};
  localparam logic [depthLog2:0]   countOne  = 1;
  localparam logic [depthLog2-1:0] ptrOne    = 1;

  logic [pidBits-1:0]   mem [depth];
  logic [depthLog2-1:0] head;
  logic [depthLog2-1:0] tail;
  logic [pidBits-1:0]   headPid;
  logic                 isDup;
  logic                 pushFire;
  logic                 popFire;

  assign empty     = (count == '0);
  assign full      = (count == countFull);
  assign pushReady = !full;
  assign headPid   = mem[head];

  // A pop never makes room for a push in the same cycle: pushReady only sees count.
  assign popFire  = popRequest && !empty;
  assign pushFire = pushValid && pushReady && (pushPid != '0) && !isDup;

`ifdef RUN_QUEUE_DEDUP_EN
  logic [(1<<pidBits)-1:0] member;

  // Popping the same PID that is being pushed frees it, so the push is allowed.
  assign isDup = member[pushPid] && !(popFire && (headPid == pushPid));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      member <= '0;
    end else begin
      if (popFire)  member[headPid] <= 1'b0;
      if (pushFire) member[pushPid] <= 1'b1;
    end
  end
`else
  assign isDup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (pushFire) mem[tail] <= pushPid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      popValid     <= 1'b0;
      popPid       <= '0;
      pushRejected <= 1'b0;
    end else begin
      popValid     <= popFire;
      pushRejected <= pushValid && !pushFire;
      if (popFire) begin
        popPid <= headPid;
        head   <= head + ptrOne;
      end
      if (pushFire) tail <= tail + ptrOne;
      case ({pushFire, popFire})
        2'b10:   count <= count + countOne;
        2'b01:   count <= count - countOne;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/process_run_queue.md
Name: process_run_queue

Overview:
- Circular FIFO of runnable PIDs. Sits directly downstream of the process allocator.
- When the allocator's `finished` rises on a create, the control logic pushes the allocator's `newPid` here.
- The core's scheduler pops the next PID to run. It re-pushes a descheduled PID on yield.
- PID 0 is reserved as "no process" and is never stored.

Parameters:
- pidBits, 8, width of a PID; matches `ADDRESS_BITS`.
- depthLog2, 4, log2 of queue depth; depth = 16 entries.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; clears all state.
- pushValid  in  1  PID on pushPid is offered this cycle.
- pushPid  in  pidBits  PID to enqueue.
- pushReady  out  1  queue accepts a push this cycle.
- pushRejected  out  1  registered one-cycle pulse: the last offered push was dropped.
- popRequest  in  1  scheduler requests the next PID.
- popValid  out  1  registered one-cycle pulse: popPid holds a dequeued PID.
- popPid  out  pidBits  dequeued PID; held until the next successful pop.
- count  out  depthLog2+1  number of stored entries, 0..depth.
- empty  out  1  count == 0.
- full  out  1  count == depth.

Behaviour:
- Reset (reset=0, asynchronous): head=0, tail=0, count=0, popValid=0, popPid=0, pushRejected=0. Storage contents are don't-care.
- pushReady = !full. It is combinational from registered count, with no path from popRequest.
- Push fires when pushValid & pushReady & pushPid != 0:
  - mem[tail] <= pushPid;
  - tail <= tail+1, wrapping modulo depth;
  - count increments.
- Pop fires when popRequest & !empty:
  - popPid <= mem[head];
  - head <= head+1, wrapping modulo depth;
  - count decrements;
  - popValid=1 in the next cycle. Latency is 1 cycle.
- popRequest while empty: no state change, popValid=0, popPid holds its old value.
- Simultaneous push and pop in one cycle:
  - Both fire and count is unchanged.
  - If count==1, the pop returns the old head entry and the pushed PID becomes the sole entry. There is no bypass.
  - If count==0, only the push fires. The pop is ignored, and a pop in the next cycle returns the pushed PID.
  - If full, the push is refused because pushReady=0 in that cycle. The pop still fires.
- pushRejected=1 in the cycle after pushValid was high and no push fired, for any of these causes:
  - full;
  - pushPid==0;
  - duplicate, only when the dedup feature is compiled in.
- Pointers are depthLog2 bits wide and wrap naturally. count is depthLog2+1 bits, so full and empty are never ambiguous.
- Reset asserted mid-operation empties the queue immediately. Any pop result not yet presented is lost: popValid=0.

Optional Feature:
- Macro: `RUN_QUEUE_DEDUP_EN`.
- When defined:
  - The block keeps a 2^pidBits-bit membership bitmap, cleared on reset.
  - A push whose PID bit is already set is dropped and raises pushRejected. The queue is unchanged.
  - A successful push sets the PID's bit; a successful pop clears it.
  - Simultaneous pop and push of the same PID: the clear and the set both apply, the set wins, and the push is accepted.
- When not defined: no bitmap. Duplicate PIDs are stored like any other PID.

Test Plan:
- Reset, then push 1 and 2, then pop twice → popValid pulses with popPid=1 then 2, one cycle after each popRequest; count 2→0; empty=1.
- Push PIDs 1..16 → full=1, pushReady=0. Push 17 → pushRejected pulse, count stays 16. Pop → popPid=1. Push 17 → accepted.
- Fill, then drain 20 times with push/pop interleaved so head and tail cross index 15→0 → PIDs emerge in exact push order; count never exceeds 16.
- With count=1 holding PID 5, push 9 and pop in the same cycle → popPid=5, count=1. Next pop → popPid=9.
- Pop while empty → popValid stays 0 and popPid is unchanged. Push pushPid=0 → pushRejected=1, count=0.
- Under `RUN_QUEUE_DEDUP_EN`:
  - push 3, then push 3 again → second push rejected, count=1;
  - pop 3, then push 3 → accepted.
  - Mid-operation, assert reset for 1 cycle with count=4 → count=0, empty=1, popValid=0 asynchronously.
